// File: rtl/vga_timing_gen.sv
// rtl/vga_timing_gen.sv - VGA column/row counters with registered sync, active and start-pulse decode
module vga_timing_gen #(
  parameter int ACTIVE_COLS   = 640,
  parameter int H_FRONT_PORCH = 16,
  parameter int H_SYNC_WIDTH  = 96,
  parameter int H_BACK_PORCH  = 48,
  parameter int ACTIVE_ROWS   = 480,
  parameter int V_FRONT_PORCH = 10,
  parameter int V_SYNC_WIDTH  = 2,
  parameter int V_BACK_PORCH  = 33,
  parameter int SYNC_POL      = 0,
  parameter int CNT_W         = 10
) (
  input  logic             i_Clk,
  input  logic             i_Reset,
  input  logic             i_Pix_En,
  output logic             o_HSync,
  output logic             o_VSync,
  output logic             o_Active,
  output logic [CNT_W-1:0] o_Col_Count,
  output logic [CNT_W-1:0] o_Row_Count,
  output logic             o_Line_Start,
  output logic             o_Frame_Start
);

  localparam int TOTAL_COLS = ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH + H_BACK_PORCH;
  localparam int TOTAL_ROWS = ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH + V_BACK_PORCH;

  // Reject geometries where a porch/sync vanishes or the counters cannot hold a full line/frame.
  if (H_FRONT_PORCH < 1 || H_SYNC_WIDTH < 1 || H_BACK_PORCH < 1 ||
      V_FRONT_PORCH < 1 || V_SYNC_WIDTH < 1 || V_BACK_PORCH < 1) begin : g_bad_porch
    $error("vga_timing_gen: every porch and sync width must be at least 1");
  end
  if (TOTAL_COLS > (1 << CNT_W) || TOTAL_ROWS > (1 << CNT_W)) begin : g_bad_width
    $error("vga_timing_gen: CNT_W too narrow for TOTAL_COLS/TOTAL_ROWS");
  end

  localparam logic [CNT_W-1:0] LAST_COL = CNT_W'(TOTAL_COLS - 1);
  localparam logic [CNT_W-1:0] LAST_ROW = CNT_W'(TOTAL_ROWS - 1);
  localparam logic [CNT_W-1:0] ACT_COLS = CNT_W'(ACTIVE_COLS);
  localparam logic [CNT_W-1:0] ACT_ROWS = CNT_W'(ACTIVE_ROWS);
  localparam logic [CNT_W-1:0] HS_FIRST = CNT_W'(ACTIVE_COLS + H_FRONT_PORCH);
  localparam logic [CNT_W-1:0] HS_LAST  = CNT_W'(ACTIVE_COLS + H_FRONT_PORCH + H_SYNC_WIDTH - 1);
  localparam logic [CNT_W-1:0] VS_FIRST = CNT_W'(ACTIVE_ROWS + V_FRONT_PORCH);
  localparam logic [CNT_W-1:0] VS_LAST  = CNT_W'(ACTIVE_ROWS + V_FRONT_PORCH + V_SYNC_WIDTH - 1);
  localparam logic             SYNC_ON  = 1'(SYNC_POL);
  localparam logic             SYNC_OFF = ~SYNC_ON;

  logic [CNT_W-1:0] col_nxt;
  logic [CNT_W-1:0] row_nxt;

  // Next position: step the column, wrap at end of line and carry into the row.
  always_comb begin
    col_nxt = o_Col_Count + 1'b1;
    row_nxt = o_Row_Count;
    if (o_Col_Count == LAST_COL) begin
      col_nxt = '0;
      row_nxt = (o_Row_Count == LAST_ROW) ? '0 : o_Row_Count + 1'b1;
    end
  end

  // Counters plus every output decoded from the next position, so all outputs move together.
  always_ff @(posedge i_Clk) begin
    if (i_Reset) begin
      o_Col_Count   <= '0;
      o_Row_Count   <= '0;
      o_Active      <= 1'b1;
      o_HSync       <= SYNC_OFF;
      o_VSync       <= SYNC_OFF;
      o_Line_Start  <= 1'b0;
      o_Frame_Start <= 1'b0;
    end else if (i_Pix_En) begin
      o_Col_Count   <= col_nxt;
      o_Row_Count   <= row_nxt;
      o_Active      <= (col_nxt < ACT_COLS) && (row_nxt < ACT_ROWS);
      o_HSync       <= (col_nxt >= HS_FIRST && col_nxt <= HS_LAST) ? SYNC_ON : SYNC_OFF;
      o_VSync       <= (row_nxt >= VS_FIRST && row_nxt <= VS_LAST) ? SYNC_ON : SYNC_OFF;
      o_Line_Start  <= (col_nxt == '0);
      o_Frame_Start <= (col_nxt == '0) && (row_nxt == '0);
    end else begin
      o_Line_Start  <= 1'b0;
      o_Frame_Start <= 1'b0;
    end
  end

endmodule

// File: tb/tb_vga_timing_gen.sv
// tb/tb_vga_timing_gen.sv - two small-geometry instances checked against a pixel-index model
module tb_vga_timing_gen;

  // Instance 0: SYNC_POL=1, 8x4 active, porches 1, syncs 2 -> 12x8.
  // Instance 1: SYNC_POL=0, 10x6 active, H 2/3/1, V 1/2/2 -> 16x11.
  localparam int AC  [2] = '{8, 10};
  localparam int HFP [2] = '{1, 2};
  localparam int HSW [2] = '{2, 3};
  localparam int HBP [2] = '{1, 1};
  localparam int AR  [2] = '{4, 6};
  localparam int VFP [2] = '{1, 1};
  localparam int VSW [2] = '{2, 2};
  localparam int VBP [2] = '{1, 2};
  localparam int POL [2] = '{1, 0};

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic en  = 1'b0;
  int   mode = 0;

  logic       hs0, vs0, act0, ls0, fs0, hs1, vs1, act1, ls1, fs1;
  logic [3:0] col0, row0;
  logic [4:0] col1, row1;

  logic [7:0] col_o [2];
  logic [7:0] row_o [2];
  logic       hs_o [2], vs_o [2], act_o [2], ls_o [2], fs_o [2];

  assign col_o[0] = {4'b0, col0};
  assign row_o[0] = {4'b0, row0};
  assign col_o[1] = {3'b0, col1};
  assign row_o[1] = {3'b0, row1};
  assign hs_o[0] = hs0;  assign hs_o[1] = hs1;
  assign vs_o[0] = vs0;  assign vs_o[1] = vs1;
  assign act_o[0] = act0; assign act_o[1] = act1;
  assign ls_o[0] = ls0;  assign ls_o[1] = ls1;
  assign fs_o[0] = fs0;  assign fs_o[1] = fs1;

  vga_timing_gen #(
    .ACTIVE_COLS(8), .H_FRONT_PORCH(1), .H_SYNC_WIDTH(2), .H_BACK_PORCH(1),
    .ACTIVE_ROWS(4), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2), .V_BACK_PORCH(1),
    .SYNC_POL(1), .CNT_W(4)
  ) dut0 (
    .i_Clk(clk), .i_Reset(rst), .i_Pix_En(en),
    .o_HSync(hs0), .o_VSync(vs0), .o_Active(act0),
    .o_Col_Count(col0), .o_Row_Count(row0),
    .o_Line_Start(ls0), .o_Frame_Start(fs0)
  );

  vga_timing_gen #(
    .ACTIVE_COLS(10), .H_FRONT_PORCH(2), .H_SYNC_WIDTH(3), .H_BACK_PORCH(1),
    .ACTIVE_ROWS(6), .V_FRONT_PORCH(1), .V_SYNC_WIDTH(2), .V_BACK_PORCH(2),
    .SYNC_POL(0), .CNT_W(5)
  ) dut1 (
    .i_Clk(clk), .i_Reset(rst), .i_Pix_En(en),
    .o_HSync(hs1), .o_VSync(vs1), .o_Active(act1),
    .o_Col_Count(col1), .o_Row_Count(row1),
    .o_Line_Start(ls1), .o_Frame_Start(fs1)
  );

  always #5 clk = ~clk;

  int errors = 0;
  int checks = 0;

  task automatic chk(input string name, input int inst, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s inst%0d: got %0d expected %0d at %0t", name, inst, act, exp, $time);
    end
  endtask

  function automatic int tcols(input int i);
    return AC[i] + HFP[i] + HSW[i] + HBP[i];
  endfunction

  function automatic int trows(input int i);
    return AR[i] + VFP[i] + VSW[i] + VBP[i];
  endfunction

  // Model: position as a linear pixel index within the frame.
  int mcol [2];
  int mrow [2];
  bit mls [2];
  bit mfs [2];
  bit mvalid = 1'b0;

  initial begin
    forever begin
      bit r, e;
      @(posedge clk);
      r = rst;
      e = en;
      for (int i = 0; i < 2; i++) begin
        if (r) begin
          mcol[i] = 0; mrow[i] = 0; mls[i] = 0; mfs[i] = 0;
        end else if (e) begin
          int idx;
          idx = (mrow[i] * tcols(i) + mcol[i] + 1) % (tcols(i) * trows(i));
          mcol[i] = idx % tcols(i);
          mrow[i] = idx / tcols(i);
          mls[i] = (mcol[i] == 0);
          mfs[i] = (idx == 0);
        end else begin
          mls[i] = 0; mfs[i] = 0;
        end
      end
      if (r) mvalid = 1'b1;
      #1;
      if (mvalid) begin
        for (int i = 0; i < 2; i++) begin
          int hs_e, vs_e, act_e;
          hs_e  = (mcol[i] >= AC[i] + HFP[i] && mcol[i] < AC[i] + HFP[i] + HSW[i]) ? POL[i] : 1 - POL[i];
          vs_e  = (mrow[i] >= AR[i] + VFP[i] && mrow[i] < AR[i] + VFP[i] + VSW[i]) ? POL[i] : 1 - POL[i];
          act_e = (mcol[i] < AC[i] && mrow[i] < AR[i]) ? 1 : 0;
          chk("col", i, 32'(col_o[i]), 32'(mcol[i]));
          chk("row", i, 32'(row_o[i]), 32'(mrow[i]));
          chk("hsync", i, 32'(hs_o[i]), 32'(hs_e));
          chk("vsync", i, 32'(vs_o[i]), 32'(vs_e));
          chk("active", i, 32'(act_o[i]), 32'(act_e));
          chk("line_start", i, 32'(ls_o[i]), 32'(mls[i]));
          chk("frame_start", i, 32'(fs_o[i]), 32'(mfs[i]));
        end
      end
    end
  end

  // Stimulus driver for toggle (mode 1) and random (mode 2) phases.
  initial begin
    forever begin
      @(negedge clk);
      if (mode == 1) begin
        en = ~en;
      end else if (mode == 2) begin
        en  = ($urandom_range(0, 3) != 0);
        rst = ($urandom_range(0, 249) == 0);
      end
    end
  end

  // Waits for a frame start, then counts one frame's worth of sync/active/line cycles.
  task automatic measure(input int i, input string tag, input int exp_period, input int exp_hs,
                         input int exp_vs, input int exp_act, input int exp_ls);
    int n, nhs, nvs, nact, nls;
    bit found;
    found = 0;
    for (int k = 0; k < 2 * exp_period + 4 && !found; k++) begin
      @(posedge clk); #1;
      if (fs_o[i]) found = 1;
    end
    chk({tag, "_fs_seen"}, i, 32'(found), 32'd1);
    n = 0; nhs = 0; nvs = 0; nact = 0; nls = 0;
    found = 0;
    while (!found && n < 2 * exp_period + 4) begin
      @(posedge clk); #1;
      n++;
      if (hs_o[i] == 1'(POL[i])) nhs++;
      if (vs_o[i] == 1'(POL[i])) nvs++;
      if (act_o[i]) nact++;
      if (ls_o[i]) nls++;
      if (fs_o[i]) found = 1;
    end
    chk({tag, "_period"}, i, 32'(n), 32'(exp_period));
    chk({tag, "_hs_cycles"}, i, 32'(nhs), 32'(exp_hs));
    chk({tag, "_vs_cycles"}, i, 32'(nvs), 32'(exp_vs));
    chk({tag, "_act_cycles"}, i, 32'(nact), 32'(exp_act));
    chk({tag, "_line_starts"}, i, 32'(nls), 32'(exp_ls));
  endtask

  initial begin
    int n0, n1;
    bit hit;

    // Reset with enable low, then with enable high.
    rst = 1'b1; en = 1'b0;
    repeat (2) @(negedge clk);
    en = 1'b1;
    @(negedge clk);
    chk("rst_col", 0, 32'(col0), 32'd0);
    chk("rst_row", 1, 32'(row1), 32'd0);
    chk("rst_active", 0, 32'(act0), 32'd1);
    chk("rst_hsync", 0, 32'(hs0), 32'd0);
    chk("rst_hsync", 1, 32'(hs1), 32'd1);
    chk("rst_vsync", 1, 32'(vs1), 32'd1);
    chk("rst_fs", 0, 32'(fs0), 32'd0);

    // First frame start after TOTAL_COLS*TOTAL_ROWS enabled edges.
    rst = 1'b0;
    n0 = -1; n1 = -1;
    for (int k = 1; k <= 400; k++) begin
      @(posedge clk); #1;
      if (fs0 && n0 < 0) n0 = k;
      if (fs1 && n1 < 0) n1 = k;
    end
    chk("first_fs_edges", 0, 32'(n0), 32'd96);
    chk("first_fs_edges", 1, 32'(n1), 32'd176);

    // Continuous enable: one full frame per instance.
    measure(0, "full", 96, 16, 24, 32, 8);
    measure(1, "full", 176, 33, 32, 60, 11);

    // Enable toggling every cycle doubles every period but keeps pulses single-cycle.
    @(negedge clk);
    mode = 1;
    measure(0, "toggle", 192, 32, 48, 64, 8);
    measure(1, "toggle", 352, 66, 64, 120, 11);
    @(negedge clk);
    mode = 0;
    en = 1'b1;

    // Reset while instance 0 sits inside both sync pulses.
    hit = 0;
    for (int k = 0; k < 200 && !hit; k++) begin
      @(posedge clk); #1;
      if (col0 == 4'd9 && row0 == 4'd6) hit = 1;
    end
    chk("reach_9_6", 0, 32'(hit), 32'd1);
    chk("pre_rst_hsync", 0, 32'(hs0), 32'd1);
    chk("pre_rst_vsync", 0, 32'(vs0), 32'd1);
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
    chk("mid_rst_col", 0, 32'(col0), 32'd0);
    chk("mid_rst_row", 0, 32'(row0), 32'd0);
    chk("mid_rst_hsync", 0, 32'(hs0), 32'd0);
    chk("mid_rst_vsync", 0, 32'(vs0), 32'd0);
    chk("mid_rst_active", 0, 32'(act0), 32'd1);
    chk("mid_rst_ls", 0, 32'(ls0), 32'd0);
    chk("mid_rst_fs", 0, 32'(fs0), 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // Random enable with occasional resets, checked cycle by cycle by the model.
    mode = 2;
    repeat (4000) @(negedge clk);
    mode = 0;
    rst = 1'b0;
    en = 1'b1;
    repeat (3) @(negedge clk);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
